vc_d_arbiter: RTL and testbench
===============================

# vc_d_arbiter

Fixed-priority arbiter and router between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmit path. It pops one word per cycle from the highest-priority non-empty VC FIFO and forwards it unchanged to D0 or D1, selected by the word's destination bit. Backpressure comes from the D FIFOs' almost-full flags. It also keeps per-destination word counters and a sticky overflow error for debug and verification.

## Interface
- data_width, 6, word width; the MSB (bit data_width-1) is the destination bit (0 = D0, 1 = D1).
- cnt_width, 8, width of the per-destination word counters.

- clk  input  1  rising-edge clock.
- reset_L  input  1  synchronous active-low reset.
- init  input  1  active-high enable; low behaves exactly like reset.
- vc0_empty, vc1_empty  input  1 each  empty flags of the VC FIFOs.
- vc0_data_out, vc1_data_out  input  data_width each  VC FIFO read data, registered; valid the cycle after rd_enable, 0 otherwise.
- d0_almost_full, d1_almost_full  input  1 each  D FIFO almost-full flags.
- d0_full, d1_full  input  1 each  D FIFO full flags; used only for error detection.
- vc0_rd_enable, vc1_rd_enable  output  1 each  pop strobes, combinational.
- d0_wr_enable, d1_wr_enable  output  1 each  push strobes, registered.
- d0_data_in, d1_data_in  output  data_width each  push data, registered; 0 when the matching wr_enable is low.
- d0_count, d1_count  output  cnt_width each  words pushed to each destination since reset; wraps modulo 2^cnt_width.
- err_overflow  output  1  sticky flag: a push was made into a full D FIFO.
- arb_idle  output  1  registered; 1 when both VC FIFOs are empty and no word is in flight.

## Operation
- Active means reset_L = 1 and init = 1. When not active, every registered state is cleared at the next clock edge.
- Pop condition in cycle N: active, d0_almost_full = 0, and d1_almost_full = 0.
  - The destination is unknown before the pop, so both flags are checked.
  - vc0_rd_enable = pop condition and !vc0_empty.
  - vc1_rd_enable = pop condition and vc0_empty and !vc1_empty.
  - Strict priority: VC0 always wins. At most one rd_enable is high in any cycle.
- Stage-1 register (s1_valid, s1_src) records the pop made in cycle N.
- In cycle N+1, stage 2 takes the word from the selected vcX_data_out and registers it.
  - It drives d0_* if the destination bit is 0, otherwise d1_*.
  - The unused destination's outputs are driven to 0.
- Pipeline stages are never stalled. Flow control relies only on almost_full.
  - Because up to 2 words are in flight, the D FIFO thresholds must be set so that almost_full asserts with at least 2 free entries (Umbral_Dx ≥ 2).
- d0_count / d1_count increment in the cycle after the matching wr_enable is high.
- err_overflow sets when dX_wr_enable = 1 and dX_full = 1 in the same cycle. It clears only on reset or init low.
- arb_idle = vc0_empty and vc1_empty and !s1_valid and no wr_enable high, registered.

## Timing
- Reset values:
  - all wr_enable, data_in, counters and err_overflow: 0.
  - s1_valid: 0.
  - arb_idle: 1.
  - rd_enables: 0 (gated by active).
- Latency: pop in cycle N, push visible in cycle N+2.
- Throughput: 1 word/cycle sustained with back-to-back pops.
- A VC FIFO holding a single word is popped once. Its empty flag updates at the next edge, so no empty pop occurs.
- almost_full rising in cycle N stops pops in cycle N. Words popped in N-1 and N-2 still land in N+0 and N+1.
- Reset or init low mid-operation: in-flight words are dropped; outputs are 0 from the next cycle.
- Counter wrap: 255 + 1 gives 0, with no flag.

## Structure
- A shared package holds the destination-bit index (data_width-1), cnt_width, and the source encoding: SRC_VC0 = 0, SRC_VC1 = 1.
- The block is a single module with no sub-module. Pop logic, a 2-stage pipeline and two counters do not justify splitting.

## Test plan
- Reset sequence: hold reset_L = 0 for 3 cycles with VC FIFOs non-empty → all rd_enable and wr_enable stay 0, counters stay 0, arb_idle = 1.
- Priority check: VC0 holds 0x05 and 0x25, VC1 holds 0x03, no backpressure.
  - Pops go VC0, VC0, VC1 in consecutive cycles.
  - Two cycles later, d0 gets 0x05, d1 gets 0x25, d0 gets 0x03.
  - Final counts: d0_count = 2, d1_count = 1.
- Backpressure: raise d1_almost_full while VC1 streams 8 words.
  - Pops stop in the same cycle the flag rises.
  - At most 2 further pushes occur.
  - Pops resume the cycle after the flag falls; no word is lost or duplicated.
- Overflow error: force d0_full = 1 while a D0 push occurs → err_overflow = 1 from the next cycle and held until init is lowered.
- Mid-stream init drop: lower init one cycle after a pop.
  - No push occurs and s1_valid clears.
  - After init returns high, the next pop has 2-cycle latency.
- Counter wrap: push 256 words to D0 → d0_count returns to 0 and err_overflow stays 0.

Source files
------------

// File: rtl/vc_d_arbiter_pkg.sv
// vc_d_arbiter_pkg: shared widths, destination-bit index and source encoding
package vc_d_arbiter_pkg;
    localparam int DATA_WIDTH = 6;
    localparam int CNT_WIDTH  = 8;
    localparam int DEST_BIT   = DATA_WIDTH - 1;
    typedef enum logic {SRC_VC0 = 1'b0, SRC_VC1 = 1'b1} src_e;
endpackage

// File: rtl/vc_d_arbiter.sv
// vc_d_arbiter: fixed-priority VC0/VC1 pop, 2-stage route to D0/D1 with counters and overflow flag
module vc_d_arbiter
    import vc_d_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data_out,
    input  logic [DATA_WIDTH-1:0] vc1_data_out,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    input  logic                  d0_full,
    input  logic                  d1_full,
    output logic                  vc0_rd_enable,
    output logic                  vc1_rd_enable,
    output logic                  d0_wr_enable,
    output logic                  d1_wr_enable,
    output logic [DATA_WIDTH-1:0] d0_data_in,
    output logic [DATA_WIDTH-1:0] d1_data_in,
    output logic [CNT_WIDTH-1:0]  d0_count,
    output logic [CNT_WIDTH-1:0]  d1_count,
    output logic                  err_overflow,
    output logic                  arb_idle
);
    logic                  active, pop_ok;
    logic                  s1_valid_q, s1_valid_d;
    src_e                  s1_src_q, s1_src_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  d0_wr_q, d0_wr_d, d1_wr_q, d1_wr_d;
    logic [DATA_WIDTH-1:0] d0_data_q, d0_data_d, d1_data_q, d1_data_d;
    logic [CNT_WIDTH-1:0]  d0_count_q, d0_count_d, d1_count_q, d1_count_d;
    logic                  err_q, err_d, idle_q, idle_d;
    always_comb begin
        active        = reset_L && init;
        // destination is unknown until the word arrives, so both flags gate the pop
        pop_ok        = active && !d0_almost_full && !d1_almost_full;
        vc0_rd_enable = pop_ok && !vc0_empty;
        vc1_rd_enable = pop_ok && vc0_empty && !vc1_empty;
        s1_valid_d    = vc0_rd_enable || vc1_rd_enable;
        s1_src_d      = vc1_rd_enable ? SRC_VC1 : SRC_VC0;
        word          = (s1_src_q == SRC_VC1) ? vc1_data_out : vc0_data_out;
        d0_wr_d       = s1_valid_q && !word[DEST_BIT];
        d1_wr_d       = s1_valid_q && word[DEST_BIT];
        d0_data_d     = d0_wr_d ? word : '0;
        d1_data_d     = d1_wr_d ? word : '0;
        d0_count_d    = d0_count_q + CNT_WIDTH'(d0_wr_q);
        d1_count_d    = d1_count_q + CNT_WIDTH'(d1_wr_q);
        err_d         = err_q || (d0_wr_q && d0_full) || (d1_wr_q && d1_full);
        idle_d        = vc0_empty && vc1_empty && !s1_valid_q && !d0_wr_q && !d1_wr_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_L || !init) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= SRC_VC0;
            d0_wr_q    <= 1'b0;
            d1_wr_q    <= 1'b0;
            d0_data_q  <= '0;
            d1_data_q  <= '0;
            d0_count_q <= '0;
            d1_count_q <= '0;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            d0_wr_q    <= d0_wr_d;
            d1_wr_q    <= d1_wr_d;
            d0_data_q  <= d0_data_d;
            d1_data_q  <= d1_data_d;
            d0_count_q <= d0_count_d;
            d1_count_q <= d1_count_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end
    assign d0_wr_enable = d0_wr_q;
    assign d1_wr_enable = d1_wr_q;
    assign d0_data_in   = d0_data_q;
    assign d1_data_in   = d1_data_q;
    assign d0_count     = d0_count_q;
    assign d1_count     = d1_count_q;
    assign err_overflow = err_q;
    assign arb_idle     = idle_q;
endmodule

// File: tb/tb_vc_d_arbiter.sv
// tb_vc_d_arbiter: directed self-checking bench with a registered VC FIFO model
module tb_vc_d_arbiter;
    import vc_d_arbiter_pkg::*;
    logic                  clk = 1'b0;
    logic                  reset_L, init, vc0_empty, vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data_out, vc1_data_out;
    logic                  d0_almost_full, d1_almost_full, d0_full, d1_full;
    logic                  vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable;
    logic [DATA_WIDTH-1:0] d0_data_in, d1_data_in;
    logic [CNT_WIDTH-1:0]  d0_count, d1_count;
    logic                  err_overflow, arb_idle;
    logic [DATA_WIDTH-1:0] q0[$], q1[$], got0[$], got1[$];
    logic                  last_r0, last_r1;
    int                    checks = 0;
    int                    failures = 0;

    vc_d_arbiter dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data_out(vc0_data_out), .vc1_data_out(vc1_data_out),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .d0_full(d0_full), .d1_full(d1_full),
        .vc0_rd_enable(vc0_rd_enable), .vc1_rd_enable(vc1_rd_enable),
        .d0_wr_enable(d0_wr_enable), .d1_wr_enable(d1_wr_enable),
        .d0_data_in(d0_data_in), .d1_data_in(d1_data_in),
        .d0_count(d0_count), .d1_count(d1_count),
        .err_overflow(err_overflow), .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put0(input logic [DATA_WIDTH-1:0] w);
        q0.push_back(w);
        vc0_empty = 1'b0;
    endtask

    task automatic put1(input logic [DATA_WIDTH-1:0] w);
        q1.push_back(w);
        vc1_empty = 1'b0;
    endtask

    // one clock: sample pops before the edge, then update the FIFO model and log pushes
    task automatic cyc();
        #1;
        last_r0 = vc0_rd_enable;
        last_r1 = vc1_rd_enable;
        @(posedge clk);
        #1;
        if (last_r0 && q0.size() > 0) vc0_data_out = q0.pop_front();
        else vc0_data_out = '0;
        if (last_r1 && q1.size() > 0) vc1_data_out = q1.pop_front();
        else vc1_data_out = '0;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        chk("rd_onehot", {31'd0, last_r0 & last_r1}, 0);
        if (d0_wr_enable) got0.push_back(d0_data_in);
        else chk("d0_data_idle_zero", d0_data_in, 0);
        if (d1_wr_enable) got1.push_back(d1_data_in);
        else chk("d1_data_idle_zero", d1_data_in, 0);
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b1;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data_out = '0; vc1_data_out = '0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        d0_full = 1'b0; d1_full = 1'b0;
        put0(6'h05); put0(6'h25); put1(6'h03);
        repeat (3) begin
            cyc();
            chk("rst_rd0", last_r0, 0);
            chk("rst_rd1", last_r1, 0);
            chk("rst_wr0", d0_wr_enable, 0);
            chk("rst_wr1", d1_wr_enable, 0);
            chk("rst_cnt0", d0_count, 0);
            chk("rst_cnt1", d1_count, 0);
            chk("rst_idle", arb_idle, 1);
            chk("rst_err", err_overflow, 0);
        end
        reset_L = 1'b1;
        cyc();
        chk("pri_pop1", {last_r1, last_r0}, 2'b01);
        chk("pri_nowr_yet", {d1_wr_enable, d0_wr_enable}, 0);
        cyc();
        chk("pri_pop2", {last_r1, last_r0}, 2'b01);
        chk("pri_push1_wr0", {d1_wr_enable, d0_wr_enable}, 2'b01);
        chk("pri_push1_data", d0_data_in, 6'h05);
        cyc();
        chk("pri_pop3", {last_r1, last_r0}, 2'b10);
        chk("pri_push2_wr1", {d1_wr_enable, d0_wr_enable}, 2'b10);
        chk("pri_push2_data", d1_data_in, 6'h25);
        cyc();
        chk("pri_pop4_none", {last_r1, last_r0}, 2'b00);
        chk("pri_push3_wr0", {d1_wr_enable, d0_wr_enable}, 2'b01);
        chk("pri_push3_data", d0_data_in, 6'h03);
        cyc();
        chk("pri_cnt0", d0_count, 2);
        chk("pri_cnt1", d1_count, 1);
        chk("pri_idle_busy", arb_idle, 0);
        cyc();
        chk("pri_idle_done", arb_idle, 1);
        chk("pri_got0_n", got0.size(), 2);
        chk("pri_got1_n", got1.size(), 1);
        got1.delete();
        for (int i = 0; i < 8; i++) put1(6'h20 | 6'(i));
        repeat (3) begin
            cyc();
            chk("bp_pop_on", last_r1, 1);
        end
        d1_almost_full = 1'b1;
        repeat (3) begin
            cyc();
            chk("bp_pop_off", {last_r1, last_r0}, 0);
        end
        chk("bp_inflight", got1.size(), 3);
        d1_almost_full = 1'b0;
        cyc();
        chk("bp_resume", last_r1, 1);
        repeat (6) cyc();
        chk("bp_total", got1.size(), 8);
        for (int i = 0; i < 8; i++) chk("bp_order", got1[i], 32'h20 + i);
        chk("bp_cnt1", d1_count, 9);
        chk("bp_cnt0", d0_count, 2);
        d0_full = 1'b1;
        put0(6'h01);
        cyc();
        chk("ovf_pop", last_r0, 1);
        chk("ovf_err_pre", err_overflow, 0);
        cyc();
        chk("ovf_push", d0_wr_enable, 1);
        chk("ovf_err_same", err_overflow, 0);
        cyc();
        chk("ovf_err_set", err_overflow, 1);
        d0_full = 1'b0;
        repeat (3) cyc();
        chk("ovf_err_held", err_overflow, 1);
        chk("ovf_cnt0", d0_count, 3);
        init = 1'b0;
        cyc();
        chk("init_err_clr", err_overflow, 0);
        chk("init_cnt0_clr", d0_count, 0);
        chk("init_cnt1_clr", d1_count, 0);
        chk("init_idle", arb_idle, 1);
        init = 1'b1;
        cyc();
        put0(6'h02);
        cyc();
        chk("drop_pop", last_r0, 1);
        init = 1'b0;
        cyc();
        chk("drop_rd_gated", {last_r1, last_r0}, 0);
        chk("drop_nowr", {d1_wr_enable, d0_wr_enable}, 0);
        cyc();
        chk("drop_nowr2", {d1_wr_enable, d0_wr_enable}, 0);
        init = 1'b1;
        cyc();
        chk("drop_s1_clr", {d1_wr_enable, d0_wr_enable}, 0);
        put0(6'h04);
        cyc();
        chk("lat_pop", last_r0, 1);
        chk("lat_nowr", d0_wr_enable, 0);
        cyc();
        chk("lat_wr", d0_wr_enable, 1);
        chk("lat_data", d0_data_in, 6'h04);
        cyc();
        chk("lat_cnt0", d0_count, 1);
        reset_L = 1'b0;
        cyc();
        reset_L = 1'b1;
        got0.delete();
        for (int i = 0; i < 256; i++) put0(6'(i % 32));
        repeat (257) cyc();
        chk("wrap_cnt255", d0_count, 255);
        cyc();
        chk("wrap_cnt0", d0_count, 0);
        chk("wrap_pushes", got0.size(), 256);
        chk("wrap_last", got0[255], 31);
        chk("wrap_err", err_overflow, 0);
        chk("wrap_cnt1", d1_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
